// File: rtl/gray_conv_arb_pkg.sv
// gray_conv_arb_pkg: shared types, constants and helpers for the round-robin Gray converter.
package gray_conv_arb_pkg;

    typedef enum logic {EMPTY, FULL} rsp_state_t;

    localparam int DATA_WIDTH_C = 4;

    function automatic int next_ptr(input int grant_idx, input int num_req);
        return (grant_idx + 1) % num_req;
    endfunction

    function automatic logic [3:0] gray_to_bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int j = 2; j >= 0; j--) b[j] = b[j+1] ^ g[j];
        return b;
    endfunction

endpackage

// File: rtl/binary_to_gray_converter_4_bit.sv
// Binary_to_Gray_Converter_4_Bit: shared 4-bit binary-to-Gray datapath, output zero when disabled.
module Binary_to_Gray_Converter_4_Bit (
    input  logic       Enable_In,
    input  logic [3:0] Binary_In,
    output logic [3:0] Gray_Out
);

    assign Gray_Out = Enable_In ? (Binary_In ^ (Binary_In >> 1)) : 4'h0;

endmodule

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: combinational round-robin pick of the first valid requester at or after ptr.
module rr_priority_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  valid,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] idx
);

    // scan farthest offset first so the nearest valid requester overwrites and wins
    always_comb begin
        int j;
        j = 0;
        grant = '0;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (valid[j]) begin
                grant = '0;
                grant[j] = 1'b1;
                idx = ID_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/gray_conv_rr_arbiter.sv
// gray_conv_rr_arbiter: round-robin sharing of one Gray converter; GRAY_CONV_ARB_G2B_EN adds per-request Gray-to-binary.
module gray_conv_rr_arbiter
    import gray_conv_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          Clock_In,
    input  logic                          Reset_n_In,
    input  logic [NUM_REQ-1:0]            Req_Valid_In,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
`ifdef GRAY_CONV_ARB_G2B_EN
    input  logic [NUM_REQ-1:0]            Req_Dir_In,
    output logic                          Rsp_Dir_Out,
`endif
    output logic [NUM_REQ-1:0]            Req_Ready_Out,
    output logic                          Rsp_Valid_Out,
    input  logic                          Rsp_Ready_In,
    output logic [DATA_WIDTH-1:0]         Rsp_Data_Out,
    output logic [ID_WIDTH-1:0]           Rsp_Id_Out
);

    generate
        if (DATA_WIDTH != DATA_WIDTH_C) begin : g_bad_width
            $error("gray_conv_rr_arbiter: DATA_WIDTH must be 4");
        end
    endgenerate

    rsp_state_t            state;
    logic [ID_WIDTH-1:0]   ptr;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   idx;
    logic                  can_load;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] gray;
    logic [DATA_WIDTH-1:0] conv;

    rr_priority_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .valid (Req_Valid_In),
        .ptr   (ptr),
        .grant (grant),
        .idx   (idx)
    );

    Binary_to_Gray_Converter_4_Bit u_conv (
        .Enable_In (1'b1),
        .Binary_In (sel_data),
        .Gray_Out  (gray)
    );

    assign can_load      = (state == EMPTY) | Rsp_Ready_In;
    assign Req_Ready_Out = Reset_n_In ? (grant & {NUM_REQ{can_load}}) : '0;
    assign accept        = |Req_Ready_Out;
    assign sel_data      = Req_Data_In[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
    assign Rsp_Valid_Out = (state == FULL);

`ifdef GRAY_CONV_ARB_G2B_EN
    logic sel_dir;
    assign sel_dir = Req_Dir_In[idx];
    assign conv    = sel_dir ? gray_to_bin(sel_data) : gray;

    // direction bit is captured alongside the converted word
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) Rsp_Dir_Out <= 1'b0;
        else if (accept) Rsp_Dir_Out <= sel_dir;
    end
`else
    assign conv = gray;
`endif

    // response FSM: load on accept, drain on consumer ready, hold on stall
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state        <= EMPTY;
            ptr          <= '0;
            Rsp_Data_Out <= '0;
            Rsp_Id_Out   <= '0;
        end else if (accept) begin
            state        <= FULL;
            ptr          <= ID_WIDTH'(next_ptr(int'(idx), NUM_REQ));
            Rsp_Data_Out <= conv;
            Rsp_Id_Out   <= idx;
        end else if (Rsp_Ready_In) begin
            state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_gray_conv_rr_arbiter.sv
// tb_gray_conv_rr_arbiter: directed scoreboard bench for gray_conv_rr_arbiter.
module tb_gray_conv_rr_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] data;
        logic       dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  vld = '0;
    logic [15:0] data = '0;
    logic [3:0]  dir = '0;
    logic [3:0]  rdy_out;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [3:0]  rsp_data;
    logic [1:0]  rsp_id;
    logic        rsp_dir;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    gray_conv_rr_arbiter dut (
        .Clock_In      (clk),
        .Reset_n_In    (rst_n),
        .Req_Valid_In  (vld),
        .Req_Data_In   (data),
`ifdef GRAY_CONV_ARB_G2B_EN
        .Req_Dir_In    (dir),
        .Rsp_Dir_Out   (rsp_dir),
`endif
        .Req_Ready_Out (rdy_out),
        .Rsp_Valid_Out (rsp_valid),
        .Rsp_Ready_In  (rsp_ready),
        .Rsp_Data_Out  (rsp_data),
        .Rsp_Id_Out    (rsp_id)
    );

`ifndef GRAY_CONV_ARB_G2B_EN
    assign rsp_dir = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] id, input logic [3:0] d, input logic dr);
        exp_t e;
        e.id = id;
        e.data = d;
        e.dir = dr;
        q.push_back(e);
    endtask

    // monitor: every consumed response is popped and compared
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("unexpected_rsp", {26'd0, rsp_id, rsp_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef GRAY_CONV_ARB_G2B_EN
                check("rsp_dir", 32'(rsp_dir), 32'(e.dir));
`endif
            end
        end
    end

    initial begin
        step();
        step();
        rst_n = 1'b1;
        // test 1: async reset while FULL with 0x5
        vld = 4'b0001;
        data[3:0] = 4'h6;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("t1_ready", 32'(rdy_out), 32'h1);
        step();
        vld = '0;
        @(negedge clk);
        check("t1_full_valid", 32'(rsp_valid), 32'h1);
        check("t1_full_data", 32'(rsp_data), 32'h5);
        #2;
        rst_n = 1'b0;
        vld = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        check("t1_rst_valid", 32'(rsp_valid), 32'h0);
        check("t1_rst_data", 32'(rsp_data), 32'h0);
        check("t1_rst_id", 32'(rsp_id), 32'h0);
        check("t1_rst_ready", 32'(rdy_out), 32'h0);
        step();
        vld = '0;
        rst_n = 1'b1;
        // test 2: single request from requester 2
        vld = 4'b0100;
        data[11:8] = 4'h6;
        @(negedge clk);
        check("t2_ready", 32'(rdy_out), 32'h4);
        push(2'd2, 4'h5, 1'b0);
        step();
        vld = '0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        // test 3: full contention from pointer 0
        vld = 4'b1111;
        data = 16'hFB81;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g_exp [5];
            logic [3:0] d_exp [5];
            g_exp = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
            d_exp = '{4'h1, 4'hC, 4'hE, 4'h8, 4'h1};
            @(negedge clk);
            check("t3_ready", 32'(rdy_out), 32'(g_exp[k]));
            if (k > 0) check("t3_no_bubble", 32'(rsp_valid), 32'h1);
            push(2'(k % 4), d_exp[k], 1'b0);
            step();
        end
        vld = '0;
        step();
        // test 4: back-pressure with 0xC/id1 held, pointer 2
        vld = 4'b0010;
        data = 16'h4083;
        @(negedge clk);
        check("t4_ready_r1", 32'(rdy_out), 32'h2);
        push(2'd1, 4'hC, 1'b0);
        step();
        rsp_ready = 1'b0;
        vld = 4'b1001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall_ready", 32'(rdy_out), 32'h0);
            check("t4_stall_valid", 32'(rsp_valid), 32'h1);
            check("t4_stall_data", 32'(rsp_data), 32'hC);
            check("t4_stall_id", 32'(rsp_id), 32'h1);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("t4_grant3", 32'(rdy_out), 32'h8);
        push(2'd3, 4'h6, 1'b0);
        step();
        @(negedge clk);
        check("t4_grant0", 32'(rdy_out), 32'h1);
        push(2'd0, 4'h2, 1'b0);
        step();
        vld = '0;
        // test 5: drain with no further requests
        @(negedge clk);
        check("t5_valid_once", 32'(rsp_valid), 32'h1);
        step();
        @(negedge clk);
        check("t5_valid_drop", 32'(rsp_valid), 32'h0);
        check("t5_data_kept", 32'(rsp_data), 32'h2);
        check("t5_id_kept", 32'(rsp_id), 32'h0);
        check("t5_ready_idle", 32'(rdy_out), 32'h0);
`ifdef GRAY_CONV_ARB_G2B_EN
        // test 6: mixed directions, pointer at 1
        step();
        vld = 4'b0110;
        dir = 4'b0010;
        data = 16'h0EE0;
        @(negedge clk);
        check("t6_grant1", 32'(rdy_out), 32'h2);
        push(2'd1, 4'hB, 1'b1);
        step();
        vld = 4'b0100;
        @(negedge clk);
        check("t6_grant2", 32'(rdy_out), 32'h4);
        push(2'd2, 4'h9, 1'b0);
        step();
        vld = '0;
        dir = '0;
`endif
        repeat (4) step();
        check("queue_empty", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gray_conv_rr_arbiter.md
Name: gray_conv_rr_arbiter

Overview:
Round-robin scheduler that shares one Binary_to_Gray_Converter_4_Bit datapath between NUM_REQ requesters. Each requester presents a valid/ready request carrying a binary word. The block grants one request per cycle, converts it and registers the result with the granted requester's ID. A valid/ready response port supports back-pressure. It sits between multiple pointer/counter producers and a single shared conversion resource.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_WIDTH, 4, width of each binary/Gray word; the converter instance is 4-bit, so only 4 is legal (elaboration error otherwise).
ID_WIDTH, $clog2(NUM_REQ), width of the response ID (derived; not overridden).

Ports:
Clock_In  input  1  single clock; all state updates on the rising edge.
Reset_n_In  input  1  asynchronous, active-low reset.
Req_Valid_In  input  NUM_REQ  per-requester request valid.
Req_Data_In  input  NUM_REQ*DATA_WIDTH  packed binary words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
Req_Ready_Out  output  NUM_REQ  one-hot grant/accept; a request transfers when valid and ready are both 1 at a clock edge.
Rsp_Valid_Out  output  1  response register holds a valid result.
Rsp_Ready_In  input  1  consumer accepts the response.
Rsp_Data_Out  output  DATA_WIDTH  converted Gray word.
Rsp_Id_Out  output  ID_WIDTH  index of the requester that produced Rsp_Data_Out.

Behaviour:
- Reset (Reset_n_In=0, asynchronous, no clock needed): Rsp_Valid_Out=0, Rsp_Data_Out=0, Rsp_Id_Out=0, priority pointer=0, state=EMPTY. Req_Ready_Out is forced to all-0 while reset is asserted. A pending response is discarded.
- State machine, 2 states:
  - EMPTY (Rsp_Valid_Out=0).
  - FULL (Rsp_Valid_Out=1).
- Transitions:
  - EMPTY to FULL on an accept.
  - FULL to EMPTY on Rsp_Ready_In=1 with no accept.
  - FULL stays FULL on Rsp_Ready_In=1 with an accept (back-to-back; throughput 1/cycle).
  - FULL stays FULL with Rsp_Ready_In=0 (stall).
- can_load = (state==EMPTY) | Rsp_Ready_In.
- Req_Ready_Out = onehot_grant & {NUM_REQ{can_load}}. It is combinational from Req_Valid_In, pointer, state and Rsp_Ready_In. At most one bit is set, and it is never set for a requester whose valid is 0.
- Arbitration: round-robin starting at the pointer. The first requester with valid=1, scanning pointer, pointer+1, ... with modulo NUM_REQ wrap, wins.
- On accept of requester k, the pointer becomes (k+1) mod NUM_REQ. With no accept, the pointer holds, including during stall.
- Latency: the request accepted at edge N appears on Rsp_* immediately after edge N, i.e. 1 cycle.
- Rsp_Data_Out = Gray(Req_Data_In[k]), computed by the converter instance with Enable_In tied to 1. Rsp_Id_Out = k.
- Stall: Rsp_Data_Out and Rsp_Id_Out are held stable while Rsp_Valid_Out=1 and Rsp_Ready_In=0.
- A requester dropping valid without a grant is legal; no request is lost once accepted.
- No valid requests: no accept. The response drains normally and Rsp_Data_Out retains its last value.
- Pointer at NUM_REQ-1 with a grant to NUM_REQ-1: the pointer wraps to 0.

Optional Feature:
Macro GRAY_CONV_ARB_G2B_EN.
- Defined: adds input Req_Dir_In [NUM_REQ]. Requester i with Req_Dir_In[i]=1 requests Gray-to-binary conversion instead: out[3]=in[3], out[j]=out[j+1]^in[j]. The direction bit is sampled with the data on accept. Adds output Rsp_Dir_Out (1 bit, reset 0) echoing it.
- Undefined: the ports are absent and all conversions are binary-to-Gray.

Decomposition:
- Package gray_conv_arb_pkg:
  - typedef enum logic {EMPTY, FULL} rsp_state_t.
  - localparam DATA_WIDTH_C=4.
  - function next_ptr(grant_idx, num_req) for modulo wrap.
- One sub-module, rr_priority_arbiter. It is purely combinational and computes the one-hot grant and encoded index from valid and pointer. The pointer register stays in the top.

Test Plan:
1. Async reset: assert Reset_n_In=0 mid-cycle while FULL (data 0x5). Rsp_Valid_Out=0, Rsp_Data_Out=0, Rsp_Id_Out=0 and Req_Ready_Out=0000 immediately, with no clock edge.
2. Single request: only requester 2 valid with 0x6, Rsp_Ready_In=1. Req_Ready_Out=0100, and the next cycle gives Rsp_Valid_Out=1, Rsp_Data_Out=0x5, Rsp_Id_Out=2.
3. Full contention: all four valid continuously with data 0x1, 0x8, 0xB, 0xF, Rsp_Ready_In=1. Grant order is 0,1,2,3,0. Responses are 0x1/id0, 0xC/id1, 0xE/id2, 0x8/id3, back-to-back with no bubbles.
4. Back-pressure: with a response 0xC/id1 held, set Rsp_Ready_In=0 for 3 cycles with requesters 0 and 3 valid.
   - Outputs stay stable and Req_Ready_Out=0000 throughout.
   - Then release: requester 3 is granted (pointer=2), and requester 0 is granted on the following cycle.
5. Drain/bubble: one accept followed by no valids. Rsp_Valid_Out goes 1 for exactly 1 cycle when Rsp_Ready_In=1, then 0, with Rsp_Data_Out retained.
6. With GRAY_CONV_ARB_G2B_EN: requester 1 sends Req_Dir_In[1]=1 with 0xE and requester 2 sends dir=0 with 0xE. Responses are 0xB/id1/dir1, then 0x9/id2/dir0.
